// File: rtl/lab2_sweep_ctrl.sv
// rtl/lab2_sweep_ctrl.sv - clocked 16-vector stimulus/response sweep for the lab 2 circuit with golden compare
// Optional build macro: LAB2_SWEEP_STOP_ON_ERR_EN (end the sweep at the first mismatching vector).
module lab2_sweep_ctrl #(
    parameter int          SETTLE = 2,
    parameter logic [15:0] EXPECT = 16'h12D2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] vec_o,
    input  logic       s_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_cnt,
    output logic       first_err_valid,
    output logic [3:0] first_err_idx
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE - 1);

    state_t     state, state_nxt;
    logic [3:0] settle_cnt, settle_cnt_nxt;
    logic [3:0] vec_nxt;
    logic       busy_nxt;
    logic       done_nxt;
    logic       pass_nxt;
    logic [4:0] err_cnt_nxt;
    logic       first_err_valid_nxt;
    logic [3:0] first_err_idx_nxt;
    logic       mismatch;
    logic       last_vec;

    assign mismatch = (s_i != EXPECT[vec_o]);

    // The sweep ends on the last vector, or on the first miss when stop-on-error is built in.
`ifdef LAB2_SWEEP_STOP_ON_ERR_EN
    assign last_vec = (vec_o == 4'd15) || mismatch;
`else
    assign last_vec = (vec_o == 4'd15);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            settle_cnt      <= 4'd0;
            vec_o           <= 4'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_cnt         <= 5'd0;
            first_err_valid <= 1'b0;
            first_err_idx   <= 4'd0;
        end else begin
            state           <= state_nxt;
            settle_cnt      <= settle_cnt_nxt;
            vec_o           <= vec_nxt;
            busy            <= busy_nxt;
            done            <= done_nxt;
            pass            <= pass_nxt;
            err_cnt         <= err_cnt_nxt;
            first_err_valid <= first_err_valid_nxt;
            first_err_idx   <= first_err_idx_nxt;
        end
    end

    always_comb begin
        state_nxt           = state;
        settle_cnt_nxt      = settle_cnt;
        vec_nxt             = vec_o;
        busy_nxt            = busy;
        done_nxt            = done;
        pass_nxt            = pass;
        err_cnt_nxt         = err_cnt;
        first_err_valid_nxt = first_err_valid;
        first_err_idx_nxt   = first_err_idx;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    err_cnt_nxt         = 5'd0;
                    first_err_valid_nxt = 1'b0;
                    first_err_idx_nxt   = 4'd0;
                    done_nxt            = 1'b0;
                    pass_nxt            = 1'b0;
                    vec_nxt             = 4'd0;
                    settle_cnt_nxt      = SETTLE_RELOAD;
                    busy_nxt            = 1'b1;
                    state_nxt           = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (settle_cnt == 4'd0) begin
                    state_nxt = ST_SAMPLE;
                end else begin
                    settle_cnt_nxt = settle_cnt - 4'd1;
                end
            end

            ST_SAMPLE: begin
                if (mismatch) begin
                    err_cnt_nxt = err_cnt + 5'd1;
                    if (!first_err_valid) begin
                        first_err_valid_nxt = 1'b1;
                        first_err_idx_nxt   = vec_o;
                    end
                end
                if (last_vec) begin
                    // Verdict includes the mismatch seen on this same closing edge.
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    pass_nxt  = (err_cnt_nxt == 5'd0);
                    state_nxt = ST_DONE;
                end else begin
                    vec_nxt        = vec_o + 4'd1;
                    settle_cnt_nxt = SETTLE_RELOAD;
                    state_nxt      = ST_WAIT;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lab2_sweep_ctrl.sv
// tb/tb_lab2_sweep_ctrl.sv - scoreboard bench for lab2_sweep_ctrl driving a modelled lab 2 circuit
module tb_lab2_sweep_ctrl;

    localparam int          SETTLE = 2;
    localparam logic [15:0] EXPECT = 16'h12D2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] vec_o;
    logic       s_i;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_cnt;
    logic       first_err_valid;
    logic [3:0] first_err_idx;

    int mode = 0;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int         errs;
        logic       fv;
        logic [3:0] fi;
        logic       pass;
        int         cycles;
        logic [3:0] last;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] vec_q[$];

    lab2_sweep_ctrl #(.SETTLE(SETTLE), .EXPECT(EXPECT)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .vec_o           (vec_o),
        .s_i             (s_i),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_cnt         (err_cnt),
        .first_err_valid (first_err_valid),
        .first_err_idx   (first_err_idx)
    );

    always #5 clk = ~clk;

    function automatic logic golden(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return (~c & (b ^ d)) | (~a & b & c);
    endfunction

    // Circuit variants: 0 correct, 1 stuck-at-0, 2 stuck-at-1, 3 inverted.
    function automatic logic circuit(input int m, input logic [3:0] v);
        case (m)
            0:       return golden(v);
            1:       return 1'b0;
            2:       return 1'b1;
            default: return ~golden(v);
        endcase
    endfunction

    always_comb s_i = circuit(mode, vec_o);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic predict(input int m);
        exp_t e;
        int   n;
        logic mis;
        e.errs = 0; e.fv = 1'b0; e.fi = 4'd0; e.last = 4'd0;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            vec_q.push_back(4'(i));
            mis = (circuit(m, 4'(i)) != golden(4'(i)));
            n++;
            e.last = 4'(i);
            if (mis) begin
                e.errs++;
                if (!e.fv) begin
                    e.fv = 1'b1;
                    e.fi = 4'(i);
                end
            end
`ifdef LAB2_SWEEP_STOP_ON_ERR_EN
            if (mis) break;
`endif
        end
        e.cycles = n * (SETTLE + 1);
        e.pass   = (e.errs == 0);
        exp_q.push_back(e);
    endtask

    task automatic run_sweep(input int m, input int pulse_at);
        exp_t       e;
        int         cyc;
        logic [3:0] last_seen;
        mode = m;
        predict(m);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        cyc = 0;
        check("start_busy", busy, 1);
        check("start_done", done, 0);
        check("vec_seq", vec_o, vec_q.pop_front());
        last_seen = vec_o;
        while (!done && cyc < 1000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = (cyc == pulse_at);
            if (vec_o != last_seen) begin
                if (vec_q.size() > 0) check("vec_seq", vec_o, vec_q.pop_front());
                else check("vec_extra", vec_o, last_seen);
                last_seen = vec_o;
            end
        end
        start = 1'b0;
        e = exp_q.pop_front();
        check("sweep_cycles", cyc, e.cycles);
        check("done", done, 1);
        check("busy_end", busy, 0);
        check("err_cnt", err_cnt, e.errs);
        check("first_err_valid", first_err_valid, e.fv);
        if (e.fv) check("first_err_idx", first_err_idx, e.fi);
        check("pass", pass, e.pass);
        check("vec_last", vec_o, e.last);
        check("vec_left", vec_q.size(), 0);
        vec_q.delete();
    endtask

    initial begin
        int k;
        repeat (2) @(negedge clk);
        check("rst_vec", vec_o, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_first_err", {first_err_valid, first_err_idx}, 0);
        rst = 1'b0;

        // Abort a sweep at vector 7 with an asynchronous reset.
        mode = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        k = 0;
        while (vec_o != 4'd7 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("reach_v7", vec_o, 7);
        #2 rst = 1'b1;
        #1;
        check("abort_vec", vec_o, 0);
        check("abort_busy", busy, 0);
        check("abort_err_cnt", err_cnt, 0);
        check("abort_first_err", {first_err_valid, first_err_idx}, 0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("idle_after_rst", {busy, done}, 0);

        run_sweep(0, -1);
        repeat (3) @(negedge clk);
        check("hold_done", {done, pass, busy}, 3'b110);
        run_sweep(1, -1);
        run_sweep(2, -1);
        run_sweep(3, -1);
        run_sweep(3, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lab2_sweep_ctrl.md
# lab2_sweep_ctrl

Self-checking stimulus/response sequencer for the lab 2 combinational circuit `s = (~c & (b ^ d)) | (~a & b & c)`. It sits directly upstream and downstream of that circuit: it drives the four inputs `{a,b,c,d}` through all 16 combinations and samples `s` after a settle window. It compares each sample against a golden truth table and reports the mismatch count, the first failing vector and a pass/fail verdict. It replaces free-running toggle stimulus with a clocked, restartable sweep under a start/done handshake.

## Interface
- `SETTLE`, 2: wait cycles per vector before sampling; legal range 1..15.
- `EXPECT`, 16'h12D2: golden truth table; bit `i` is the expected `s` for `{a,b,c,d} = i`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: sweep request; sampled only in IDLE or DONE.
- `vec_o` out 4: drives `{a,b,c,d}`; `a` = bit 3, `d` = bit 0.
- `s_i` in 1: circuit output under test.
- `busy` out 1: high while a sweep runs.
- `done` out 1: high from sweep completion until the next accepted start.
- `pass` out 1: valid while `done`; 1 iff `err_cnt == 0`.
- `err_cnt` out 5: number of mismatching vectors, 0..16.
- `first_err_valid` out 1: at least one mismatch recorded in the current sweep.
- `first_err_idx` out 4: index of the first mismatching vector; valid when `first_err_valid` is high.

## Operation
- States: IDLE, WAIT, SAMPLE, DONE.
- Reset (asynchronous, any state): state goes to IDLE. `vec_o`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `first_err_valid`=0, `first_err_idx`=0, settle counter=0.
- IDLE or DONE with `start`=1: clear `err_cnt`, `first_err_valid`, `first_err_idx`, `done` and `pass`. Set `vec_o`=0, settle counter=`SETTLE`-1, `busy`=1. Go to WAIT.
- WAIT: hold `vec_o`. If the counter is 0, go to SAMPLE; otherwise decrement the counter.
- SAMPLE: at the closing edge, compare `s_i` with `EXPECT[vec_o]`.
  - On mismatch: `err_cnt` increments. If `first_err_valid`=0, set `first_err_idx`=`vec_o` and `first_err_valid`=1.
  - If `vec_o`==15: go to DONE. Set `busy`=0, `done`=1, and `pass`=1 iff the final count is 0, including the mismatch from this same edge.
  - Otherwise: increment `vec_o`, reload the counter with `SETTLE`-1, and go to WAIT.
- DONE: outputs hold. `vec_o` stays at its last value (15, or the stop vector).
- `start` while `busy` is ignored and has no effect on the sweep.
- `vec_o` never wraps inside a sweep. The increment from 15 is suppressed.
- `err_cnt` is 5 bits and cannot overflow, because at most 16 vectors are compared.

## Timing
- Start is accepted at edge E0. `vec_o`=0 and `busy`=1 are visible after E0.
- Each vector is held for `SETTLE`+1 cycles: `SETTLE` in WAIT, then 1 in SAMPLE.
- `s_i` is sampled at the last edge of each vector's window. The circuit therefore has `SETTLE`+1 cycles to settle.
- A full sweep raises `done` 16·(`SETTLE`+1) cycles after E0. With the default, that is 48 cycles.
- `err_cnt` and `first_err_*` update at the same edge as the sample; there is no extra latency.
- A new start in DONE restarts immediately: `done` drops at the accepting edge.
- Reset mid-sweep aborts at once. No partial result survives reset.

## Configuration
- `LAB2_SWEEP_STOP_ON_ERR_EN` defined:
  - The first mismatch ends the sweep at that SAMPLE edge.
  - The block goes to DONE with `err_cnt`=1, `pass`=0, and `vec_o` held at the failing index.
- Undefined (default): all 16 vectors are always swept and every mismatch is counted.

## Test plan
- Reset check: assert `rst` mid-sweep (vector 7) -> all outputs return to 0 immediately; a following start sweeps from vector 0.
- Correct circuit, `SETTLE`=2 -> after 48 cycles: `done`=1, `pass`=1, `err_cnt`=0, `first_err_valid`=0; `vec_o` visits 0..15 in order.
- `s_i` stuck at 0 -> `err_cnt`=6, `first_err_idx`=1, `pass`=0.
- `s_i` stuck at 1 -> `err_cnt`=10, `first_err_idx`=0.
- `s_i` inverted -> `err_cnt`=16; then a start pulse during `busy` of a second sweep -> sweep length is still 48 cycles.
- `LAB2_SWEEP_STOP_ON_ERR_EN`, stuck at 0, `SETTLE`=2 -> `done` after 6 cycles with `err_cnt`=1, `vec_o`=1 and `first_err_idx`=1.
